// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared types and default sizes for the architectural register file and its
// scoreboard. The module parameters of regfile_sb default to these constants.
//   uop_reg_t : register index
//   uop_val_t : register data (XLEN bits)
//   rf_tag_t  : producer tag carried by reservations and writebacks
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int NREGS = 32;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int REG_W = $clog2(NREGS);

  typedef logic [REG_W-1:0] uop_reg_t;
  typedef logic [XLEN-1:0]  uop_val_t;
  typedef logic [TAG_W-1:0] rf_tag_t;

endpackage : regfile_sb_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy bit and producer tag. A reservation sets busy and records
// the tag; a writeback whose tag matches the recorded one clears busy. A
// reservation and a writeback to the same register in one cycle leave the
// register reserved under the new tag. Register 0 is never busy.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   rsv_en_i/rsv_addr_i/rsv_tag_i  destination reservation
//   wr_en_i/wr_addr_i/wr_tag_i     writeback ports (highest index wins)
//   busy_o, tag_o               registered busy/tag state of every register
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter  int NREGS  = regfile_sb_pkg::NREGS,
  parameter  int NWRITE = 1,
  parameter  int TAG_W  = regfile_sb_pkg::TAG_W,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rsv_en_i,
  input  logic [AW-1:0]                    rsv_addr_i,
  input  logic [TAG_W-1:0]                 rsv_tag_i,
  input  logic [NWRITE-1:0]                wr_en_i,
  input  logic [NWRITE-1:0][AW-1:0]        wr_addr_i,
  input  logic [NWRITE-1:0][TAG_W-1:0]     wr_tag_i,
  output logic [NREGS-1:0]                 busy_o,
  output logic [NREGS-1:0][TAG_W-1:0]      tag_o
);

  logic [NREGS-1:0]            busy_q, busy_d;
  logic [NREGS-1:0][TAG_W-1:0] tag_q,  tag_d;

  always_comb begin
    logic             hit;
    logic [TAG_W-1:0] hit_tag;
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value; every variable gets a default first so no latch is inferred.
    busy_d  = busy_q;
    tag_d   = tag_q;
    hit     = 1'b0;
    hit_tag = '0;
    for (int r = 1; r < NREGS; r++) begin
      // Select the writeback that owns register r (highest port index wins).
      hit     = 1'b0;
      hit_tag = '0;
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_en_i[w] && wr_addr_i[w] == AW'(r)) begin
          hit     = 1'b1;
          hit_tag = wr_tag_i[w];
        end
      end
      if (rsv_en_i && rsv_addr_i == AW'(r)) begin
        // A new reservation outranks a completing producer in the same cycle.
        busy_d[r] = 1'b1;
        tag_d[r]  = rsv_tag_i;
      end else if (hit && busy_q[r] && hit_tag == tag_q[r]) begin
        // Only the most recent producer may release the register; stale
        // producers after a WAW leave it busy.
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign busy_o = busy_q;
  assign tag_o  = tag_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Multi-port integer register file with a per-register scoreboard. Reads are
// combinational, writes and reservations take effect at the rising edge.
// Register 0 reads as zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read that hits
// an enabled write address returns that write's data in the same cycle and
// reports not-busy if the write's tag releases the register.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rd_addr_i[NREAD]      read address per port
//   rd_val_o[NREAD]       read data per port
//   rd_busy_o[NREAD]      addressed register has an outstanding reservation
//   rsv_en_i/_addr_i/_tag_i  reserve a destination register with a tag
//   wr_en_i/_addr_i/_val_i/_tag_i[NWRITE]  writeback ports
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter  int NREGS  = regfile_sb_pkg::NREGS,
  parameter  int XLEN   = regfile_sb_pkg::XLEN,
  parameter  int NREAD  = 2,
  parameter  int NWRITE = 1,
  parameter  int TAG_W  = regfile_sb_pkg::TAG_W,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREAD-1:0][AW-1:0]      rd_addr_i,
  output logic [NREAD-1:0][XLEN-1:0]    rd_val_o,
  output logic [NREAD-1:0]              rd_busy_o,
  input  logic                          rsv_en_i,
  input  logic [AW-1:0]                 rsv_addr_i,
  input  logic [TAG_W-1:0]              rsv_tag_i,
  input  logic [NWRITE-1:0]             wr_en_i,
  input  logic [NWRITE-1:0][AW-1:0]     wr_addr_i,
  input  logic [NWRITE-1:0][XLEN-1:0]   wr_val_i,
  input  logic [NWRITE-1:0][TAG_W-1:0]  wr_tag_i
);

  logic [NREGS-1:0][XLEN-1:0]  value_q, value_d;
  logic [NREGS-1:0]            busy;
  logic [NREGS-1:0][TAG_W-1:0] tag;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE),
    .TAG_W  (TAG_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .rsv_tag_i  (rsv_tag_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_tag_i   (wr_tag_i),
    .busy_o     (busy),
    .tag_o      (tag)
  );

  // Value array: ascending port loop makes the highest port win on collisions.
  always_comb begin
    value_d = value_q;
    for (int w = 0; w < NWRITE; w++) begin
      if (wr_en_i[w] && wr_addr_i[w] != '0) begin
        value_d[wr_addr_i[w]] = wr_val_i[w];
      end
    end
  end

  // NOTE: the array must clear on reset, so it is built from flops with an
  // asynchronous reset rather than from a RAM macro without one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  // Read ports. Entry 0 of value_q and busy is never written, so r0 reads zero.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    logic             byp_hit;
    logic [TAG_W-1:0] byp_tag;
    byp_hit = 1'b0;
    byp_tag = '0;
`endif
    for (int p = 0; p < NREAD; p++) begin
      rd_val_o[p]  = value_q[rd_addr_i[p]];
      rd_busy_o[p] = busy[rd_addr_i[p]];
`ifdef REGFILE_BYPASS_EN
      byp_hit = 1'b0;
      byp_tag = '0;
      // Forwarding is suppressed during reset so outputs read as cleared.
      for (int w = 0; w < NWRITE; w++) begin
        if (!rst && wr_en_i[w] && rd_addr_i[p] != '0 && wr_addr_i[w] == rd_addr_i[p]) begin
          byp_hit     = 1'b1;
          byp_tag     = wr_tag_i[w];
          rd_val_o[p] = wr_val_i[w];
        end
      end
      // A same-cycle reservation of this register keeps the registered busy.
      if (byp_hit && byp_tag == tag[rd_addr_i[p]] &&
          !(rsv_en_i && rsv_addr_i == rd_addr_i[p])) begin
        rd_busy_o[p] = 1'b0;
      end
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  // Tags are only consumed by the bypass path; keep them visibly intentional.
  logic unused_tag;
  assign unused_tag = ^tag;
`endif

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb: directed scenarios with fixed expected
// values, then randomized traffic compared against an array-based model.
// -----------------------------------------------------------------------------
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int NREAD  = 2;
  localparam int NWRITE = 1;

  logic                       clk;
  logic                       rst;
  uop_reg_t [NREAD-1:0]       rd_addr;
  uop_val_t [NREAD-1:0]       rd_val;
  logic     [NREAD-1:0]       rd_busy;
  logic                       rsv_en;
  uop_reg_t                   rsv_addr;
  rf_tag_t                    rsv_tag;
  logic     [NWRITE-1:0]      wr_en;
  uop_reg_t [NWRITE-1:0]      wr_addr;
  uop_val_t [NWRITE-1:0]      wr_val;
  rf_tag_t  [NWRITE-1:0]      wr_tag;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  uop_val_t m_val  [NREGS];
  bit       m_busy [NREGS];
  rf_tag_t  m_tag  [NREGS];

  regfile_sb #(
    .NREGS  (NREGS),
    .XLEN   (XLEN),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .TAG_W  (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr),
    .rd_val_o   (rd_val),
    .rd_busy_o  (rd_busy),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .rsv_tag_i  (rsv_tag),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_val_i   (wr_val),
    .wr_tag_i   (wr_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_val[r]  = '0;
      m_busy[r] = 1'b0;
      m_tag[r]  = '0;
    end
  endfunction

  // Architectural effect of one clock edge with the currently driven inputs.
  function automatic void model_update();
    bit      won     [NREGS];
    rf_tag_t won_tag [NREGS];
    for (int r = 0; r < NREGS; r++) begin
      won[r]     = 1'b0;
      won_tag[r] = '0;
    end
    for (int w = 0; w < NWRITE; w++) begin
      if (wr_en[w] && wr_addr[w] != 0) begin
        m_val[wr_addr[w]]   = wr_val[w];
        won[wr_addr[w]]     = 1'b1;
        won_tag[wr_addr[w]] = wr_tag[w];
      end
    end
    for (int r = 1; r < NREGS; r++)
      if (won[r] && m_busy[r] && won_tag[r] == m_tag[r]) m_busy[r] = 1'b0;
    if (rsv_en && rsv_addr != 0) begin
      m_busy[rsv_addr] = 1'b1;
      m_tag[rsv_addr]  = rsv_tag;
    end
  endfunction

  // Expected combinational read of register a in the current cycle.
  function automatic void exp_read(input int a, output uop_val_t v, output logic b);
    v = (a == 0) ? '0 : m_val[a];
    b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0 && !rst) begin
      bit      hit = 1'b0;
      rf_tag_t t   = '0;
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_en[w] && int'(wr_addr[w]) == a) begin
          hit = 1'b1;
          v   = wr_val[w];
          t   = wr_tag[w];
        end
      end
      if (hit && t == m_tag[a] && !(rsv_en && int'(rsv_addr) == a)) b = 1'b0;
    end
`endif
  endfunction

  task automatic drive_idle();
    rsv_en   = 1'b0;
    rsv_addr = '0;
    rsv_tag  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_val   = '0;
    wr_tag   = '0;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic reserve(input int a, input int t);
    rsv_en   = 1'b1;
    rsv_addr = uop_reg_t'(a);
    rsv_tag  = rf_tag_t'(t);
  endtask

  task automatic write0(input int a, input uop_val_t v, input int t);
    wr_en[0]   = 1'b1;
    wr_addr[0] = uop_reg_t'(a);
    wr_val[0]  = v;
    wr_tag[0]  = rf_tag_t'(t);
  endtask

  task automatic check_rd(input string name, input int a, input uop_val_t ev, input logic eb);
    rd_addr[0] = uop_reg_t'(a);
    rd_addr[1] = uop_reg_t'(a);
    #1;
    check({name, "_val0"},  rd_val[0],  ev);
    check({name, "_busy0"}, rd_busy[0], eb);
    check({name, "_val1"},  rd_val[1],  ev);
  endtask

  initial begin
    uop_val_t ev;
    logic     eb;

    rst = 1'b1;
    drive_idle();
    rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_rd("reset_init", 5, 32'h0, 1'b0);

    // Reset while r5 holds data and is reserved
    write0(5, 32'hDEADBEEF, 0);
    reserve(5, 2);
    tick();
    check_rd("pre_rst", 5, 32'hDEADBEEF, 1'b1);
    rst = 1'b1;
    check_rd("in_rst", 5, 32'h0, 1'b0);
    model_reset();
    rst = 1'b0;
    tick();
    check_rd("post_rst", 5, 32'h0, 1'b0);

    // Register 0 ignores writes and reservations
    write0(0, 32'h1234, 0);
    reserve(0, 1);
    check_rd("r0_same", 0, 32'h0, 1'b0);
    tick();
    check_rd("r0_after", 0, 32'h0, 1'b0);

    // Reserve r7 tag 3, matching writeback two cycles later
    reserve(7, 3);
    tick();
    check_rd("r7_rsv", 7, 32'h0, 1'b1);
    tick();
    check_rd("r7_wait", 7, 32'h0, 1'b1);
    write0(7, 32'h55, 3);
`ifdef REGFILE_BYPASS_EN
    check_rd("r7_wr_cycle", 7, 32'h55, 1'b0);
`else
    check_rd("r7_wr_cycle", 7, 32'h0, 1'b1);
`endif
    tick();
    check_rd("r7_done", 7, 32'h55, 1'b0);

    // WAW: only the latest producer releases r9
    reserve(9, 1);
    tick();
    reserve(9, 2);
    tick();
    write0(9, 32'hA, 1);
    tick();
    check_rd("waw_stale", 9, 32'hA, 1'b1);
    write0(9, 32'hB, 2);
    tick();
    check_rd("waw_final", 9, 32'hB, 1'b0);

    // Same-cycle reserve (tag 6) and matching writeback (tag 5) on r4
    reserve(4, 5);
    tick();
    reserve(4, 6);
    write0(4, 32'h44, 5);
    tick();
    check_rd("r4_collide", 4, 32'h44, 1'b1);
    write0(4, 32'h45, 5);
    tick();
    check_rd("r4_oldtag", 4, 32'h45, 1'b1);
    write0(4, 32'h46, 6);
    tick();
    check_rd("r4_newtag", 4, 32'h46, 1'b0);

    // Write and read r3 in the same cycle
    write0(3, 32'h77, 0);
`ifdef REGFILE_BYPASS_EN
    check_rd("r3_same", 3, 32'h77, 1'b0);
`else
    check_rd("r3_same", 3, 32'h0, 1'b0);
`endif
    tick();
    check_rd("r3_next", 3, 32'h77, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
      end
      rsv_en   = ($urandom_range(0, 9) < 4);
      rsv_addr = uop_reg_t'($urandom_range(0, 7));
      rsv_tag  = rf_tag_t'($urandom_range(0, 3));
      for (int w = 0; w < NWRITE; w++) begin
        wr_en[w]   = ($urandom_range(0, 9) < 6);
        wr_addr[w] = uop_reg_t'($urandom_range(0, 7));
        wr_val[w]  = $urandom;
        wr_tag[w]  = rf_tag_t'($urandom_range(0, 3));
      end
      for (int p = 0; p < NREAD; p++) rd_addr[p] = uop_reg_t'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < NREAD; p++) begin
        exp_read(int'(rd_addr[p]), ev, eb);
        check("rand_val",  rd_val[p],  ev);
        check("rand_busy", rd_busy[p], eb);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_sb
